memory_access_stage: RTL and testbench
======================================

// Module: memory_access_stage
// PURPOSE
//  MA pipeline stage, directly downstream of EX. Consumes the EX/MA register outputs:
//   - ctrl word, instruction, PC, ALU result, forwarded rs2, byte enable, addr offset, br_en.
//  Runs the load/store handshake with the data cache and stalls the pipe until dmem_resp.
//  Aligns load data (sign/zero extend) and store data (lane shift).
//  Registers everything into the MA/WB register for writeback.
// PARAMETERS
//  XLEN    32  datapath width (only 32 supported)
//  CNT_W   32  width of saturating stall-cycle performance counter
// PORTS
//  clk              in   1      clock, all state on rising edge
//  rst              in   1      asynchronous, active-high reset
//  ctrl_word_in     in   struct rv32i_control_word from EX/MA register
//  instruction_in   in   32     instruction from EX/MA
//  PC_in            in   32     PC from EX/MA
//  alu_in           in   32     ALU result / effective address
//  rs2_in           in   32     forwarded store data
//  mem_byte_enable  in   4      byte mask, already shifted by offset in EX
//  addr_offset      in   2      effective address [1:0]
//  br_en_in         in   1      branch compare result
//  dmem_rdata       in   32     cache read data, valid with dmem_resp
//  dmem_resp        in   1      cache completion pulse
//  dmem_read        out  1      read request
//  dmem_write       out  1      write request
//  dmem_address     out  32     {alu_in[31:2],2'b00}
//  dmem_wdata       out  32     rs2_in << (8*addr_offset)
//  dmem_byte_enable out  4      mem_byte_enable on stores, 4'b1111 on loads
//  MA_stall         out  1      freezes IF/ID/EX/MA registers
//  miss             out  1      high while in WAIT (access took >1 cycle)
//  stall_cycles     out  CNT_W  saturating count of cycles with MA_stall=1
//  ctrl_word_wb, instruction_wb, PC_wb, alu_wb, mem_rdata_wb (32), br_en_wb (1),
//  rmask_wb/wmask_wb (4)  out  MA/WB register contents; masks feed the rvfi monitor
// BEHAVIOUR
//  - Memory op: mem_op = opcode in {op_load, op_store}. Non-memory ops never raise a request.
//  - FSM, two states:
//    - IDLE, mem_op=1: request asserted combinationally in the same cycle.
//      - dmem_resp=1 that cycle: complete, stay IDLE.
//      - otherwise: go to WAIT.
//    - WAIT: hold the request and address/wdata/byte enable stable.
//      - dmem_resp=1: complete, go to IDLE.
//  - MA_stall = mem_op & ~dmem_resp, in both states. A zero-wait response gives zero stall cycles.
//  - Completion cycle: MA_stall=0, so MA/WB captures the instruction.
//    The next instruction enters MA on the same edge. That instruction sees IDLE, so there is no double issue.
//  - dmem_read and dmem_write are never both high.
//  - Load extract, indexed by funct3 = instruction_in[14:12]:
//    - lb/lbu: byte at addr_offset, sign/zero extended.
//    - lh/lhu: halfword at addr_offset[1], sign/zero extended.
//    - lw: full word, offset ignored.
//  - Misaligned lh/lw are not trapped; byte enable is truncated to 4 bits and data is as extracted above.
//  - MA/WB register:
//    - loads whenever MA_stall=0;
//    - when MA_stall=1, holds its value and no bubble is inserted;
//    - on non-memory ops, mem_rdata_wb=0, rmask_wb=0, wmask_wb=0.
//  - stall_cycles increments each cycle MA_stall=1 and saturates at all-ones.
//  - Reset (async, any state, including mid-request):
//    - FSM to IDLE; stall_cycles=0; miss=0;
//    - all MA/WB outputs=0;
//    - dmem_read/dmem_write low immediately, MA_stall low.
//    - A dmem_resp arriving after reset while no request is outstanding is ignored.
// TESTING
//  - lw, alu_in=0x100, dmem_resp 3 cycles after request, rdata=0xDEADBEEF:
//    -> MA_stall high 3 cycles, miss high 2, mem_rdata_wb=0xDEADBEEF, stall_cycles=3.
//  - lb offset 3, rdata=0x80FF_0000 -> mem_rdata_wb=0xFFFFFF80; lbu same -> 0x00000080.
//  - sh offset 2, rs2=0x0000ABCD -> dmem_wdata=0xABCD0000, dmem_byte_enable=4'b1100, dmem_write=1.
//  - Back-to-back lw then sw, each with resp in the same cycle
//    -> zero stall cycles, two requests on consecutive cycles, no duplicate.
//  - Add (op_reg) -> no dmem_read/dmem_write, MA_stall=0, alu_wb=alu_in one cycle later.
//  - rst asserted in WAIT -> dmem_read drops with no clock edge, all outputs 0;
//    a later stray dmem_resp -> no WB update.

Source files
------------

// File: rtl/memory_access_stage.sv
// Memory-access pipeline stage: data-cache load/store handshake, load/store lane
// alignment, stall generation and the MA/WB pipeline register.
module memory_access_stage #(
    parameter int XLEN   = 32,
    parameter int CNT_W  = 32,
    parameter int CTRL_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CTRL_W-1:0] ctrl_word_in,
    input  logic [XLEN-1:0]   instruction_in,
    input  logic [XLEN-1:0]   PC_in,
    input  logic [XLEN-1:0]   alu_in,
    input  logic [XLEN-1:0]   rs2_in,
    input  logic [3:0]        mem_byte_enable,
    input  logic [1:0]        addr_offset,
    input  logic              br_en_in,
    input  logic [XLEN-1:0]   dmem_rdata,
    input  logic              dmem_resp,
    output logic              dmem_read,
    output logic              dmem_write,
    output logic [XLEN-1:0]   dmem_address,
    output logic [XLEN-1:0]   dmem_wdata,
    output logic [3:0]        dmem_byte_enable,
    output logic              MA_stall,
    output logic              miss,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CTRL_W-1:0] ctrl_word_wb,
    output logic [XLEN-1:0]   instruction_wb,
    output logic [XLEN-1:0]   PC_wb,
    output logic [XLEN-1:0]   alu_wb,
    output logic [XLEN-1:0]   mem_rdata_wb,
    output logic              br_en_wb,
    output logic [3:0]        rmask_wb,
    output logic [3:0]        wmask_wb
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] WAIT     = 1'b1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [0:0]      state_reg;
    logic [0:0]      state_next;
    logic            is_load;
    logic            is_store;
    logic            mem_op;
    logic [2:0]      funct3;
    logic [7:0]      byte_lane [4];
    logic [7:0]      sel_byte;
    logic [15:0]     sel_half;
    logic [XLEN-1:0] load_data;

    assign is_load  = (instruction_in[6:0] == OP_LOAD);
    assign is_store = (instruction_in[6:0] == OP_STORE);
    assign mem_op   = is_load | is_store;
    assign funct3   = instruction_in[14:12];

    // Requests are gated by rst so they drop the instant reset asserts.
    assign dmem_read        = is_load & ~rst;
    assign dmem_write       = is_store & ~rst;
    assign MA_stall         = mem_op & ~dmem_resp & ~rst;
    assign dmem_address     = {alu_in[XLEN-1:2], 2'b00};
    assign dmem_wdata       = rs2_in << {addr_offset, 3'b000};
    assign dmem_byte_enable = is_load ? 4'b1111 : mem_byte_enable;
    // The completion cycle itself is not counted as a miss cycle.
    assign miss             = (state_reg == WAIT) & ~dmem_resp;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (mem_op && !dmem_resp) state_next = WAIT;
            WAIT:    if (dmem_resp || !mem_op) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign byte_lane[gi] = dmem_rdata[8*gi +: 8];
    end

    assign sel_byte = byte_lane[addr_offset];
    assign sel_half = addr_offset[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        load_data = dmem_rdata;
        case (funct3)
            3'b000:  load_data = {{(XLEN-8){sel_byte[7]}}, sel_byte};
            3'b100:  load_data = {{(XLEN-8){1'b0}}, sel_byte};
            3'b001:  load_data = {{(XLEN-16){sel_half[15]}}, sel_half};
            3'b101:  load_data = {{(XLEN-16){1'b0}}, sel_half};
            default: load_data = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            stall_cycles <= '0;
        end else begin
            state_reg <= state_next;
            if (MA_stall && stall_cycles != CNT_MAX)
                stall_cycles <= stall_cycles + 1'b1;
        end
    end

    // MA/WB register holds (no bubble) while the stage is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_word_wb   <= '0;
            instruction_wb <= '0;
            PC_wb          <= '0;
            alu_wb         <= '0;
            mem_rdata_wb   <= '0;
            br_en_wb       <= 1'b0;
            rmask_wb       <= 4'b0000;
            wmask_wb       <= 4'b0000;
        end else if (!MA_stall) begin
            ctrl_word_wb   <= ctrl_word_in;
            instruction_wb <= instruction_in;
            PC_wb          <= PC_in;
            alu_wb         <= alu_in;
            mem_rdata_wb   <= is_load ? load_data : '0;
            br_en_wb       <= br_en_in;
            rmask_wb       <= is_load ? mem_byte_enable : 4'b0000;
            wmask_wb       <= is_store ? mem_byte_enable : 4'b0000;
        end
    end

endmodule

// File: tb/tb_memory_access_stage.sv
// Scoreboard bench for memory_access_stage: expected MA/WB contents are queued
// when an instruction is driven and compared when the stage releases it.
module tb_memory_access_stage;

    localparam int CNT_W = 4;
    localparam int CNT_MAX = 15;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      ctrl_word_in;
    logic [31:0]      instruction_in;
    logic [31:0]      PC_in;
    logic [31:0]      alu_in;
    logic [31:0]      rs2_in;
    logic [3:0]       mem_byte_enable;
    logic [1:0]       addr_offset;
    logic             br_en_in;
    logic [31:0]      dmem_rdata;
    logic             dmem_resp;
    logic             dmem_read;
    logic             dmem_write;
    logic [31:0]      dmem_address;
    logic [31:0]      dmem_wdata;
    logic [3:0]       dmem_byte_enable;
    logic             MA_stall;
    logic             miss;
    logic [CNT_W-1:0] stall_cycles;
    logic [31:0]      ctrl_word_wb;
    logic [31:0]      instruction_wb;
    logic [31:0]      PC_wb;
    logic [31:0]      alu_wb;
    logic [31:0]      mem_rdata_wb;
    logic             br_en_wb;
    logic [3:0]       rmask_wb;
    logic [3:0]       wmask_wb;

    typedef struct packed {
        logic [31:0] ctrl;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic        br;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
    } wb_t;

    wb_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  exp_cnt  = 0;

    localparam logic [31:0] I_LW  = 32'h00012083;
    localparam logic [31:0] I_LB  = 32'h00010083;
    localparam logic [31:0] I_LBU = 32'h00014083;
    localparam logic [31:0] I_LH  = 32'h00011083;
    localparam logic [31:0] I_LHU = 32'h00015083;
    localparam logic [31:0] I_SH  = 32'h00209023;
    localparam logic [31:0] I_SW  = 32'h0020A023;
    localparam logic [31:0] I_ADD = 32'h002081B3;

    memory_access_stage #(.XLEN(32), .CNT_W(CNT_W), .CTRL_W(32)) dut (
        .clk(clk), .rst(rst),
        .ctrl_word_in(ctrl_word_in), .instruction_in(instruction_in), .PC_in(PC_in),
        .alu_in(alu_in), .rs2_in(rs2_in), .mem_byte_enable(mem_byte_enable),
        .addr_offset(addr_offset), .br_en_in(br_en_in),
        .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_address(dmem_address),
        .dmem_wdata(dmem_wdata), .dmem_byte_enable(dmem_byte_enable),
        .MA_stall(MA_stall), .miss(miss), .stall_cycles(stall_cycles),
        .ctrl_word_wb(ctrl_word_wb), .instruction_wb(instruction_wb), .PC_wb(PC_wb),
        .alu_wb(alu_wb), .mem_rdata_wb(mem_rdata_wb), .br_en_wb(br_en_wb),
        .rmask_wb(rmask_wb), .wmask_wb(wmask_wb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic compare_wb();
        wb_t e;
        if (exp_q.size() == 0) begin
            check("wb_unexpected_capture", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("ctrl_word_wb",   ctrl_word_wb,   e.ctrl);
            check("instruction_wb", instruction_wb, e.instr);
            check("PC_wb",          PC_wb,          e.pc);
            check("alu_wb",         alu_wb,         e.alu);
            check("mem_rdata_wb",   mem_rdata_wb,   e.rdata);
            check("br_en_wb",       {31'b0, br_en_wb}, {31'b0, e.br});
            check("rmask_wb",       {28'b0, rmask_wb}, {28'b0, e.rmask});
            check("wmask_wb",       {28'b0, wmask_wb}, {28'b0, e.wmask});
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the instruction retires from MA.
    task automatic run_op(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] alu,
                          input logic [31:0] rs2, input logic [3:0] be, input logic br,
                          input logic [31:0] rdata, input logic [31:0] exp_rdata, input int delay,
                          output int stalls, output int misses, output int reads, output int writes,
                          output logic [31:0] s_addr, output logic [31:0] s_wdata,
                          output logic [3:0] s_be);
        wb_t  e;
        logic is_ld, is_st, stall_now;
        is_ld = (instr[6:0] == 7'b0000011);
        is_st = (instr[6:0] == 7'b0100011);
        ctrl_word_in    = pc ^ 32'h5A5A_5A5A;
        instruction_in  = instr;
        PC_in           = pc;
        alu_in          = alu;
        rs2_in          = rs2;
        mem_byte_enable = be;
        addr_offset     = alu[1:0];
        br_en_in        = br;
        e.ctrl  = pc ^ 32'h5A5A_5A5A;
        e.instr = instr;
        e.pc    = pc;
        e.alu   = alu;
        e.rdata = exp_rdata;
        e.br    = br;
        e.rmask = is_ld ? be : 4'b0000;
        e.wmask = is_st ? be : 4'b0000;
        exp_q.push_back(e);
        stalls = 0; misses = 0; reads = 0; writes = 0;
        s_addr = '0; s_wdata = '0; s_be = '0;
        for (int c = 0; c <= delay; c++) begin
            dmem_resp  = (c == delay) && (is_ld || is_st);
            dmem_rdata = (c == delay) ? rdata : 32'h0BAD_0BAD;
            #2;
            if (c == 0) begin
                s_addr = dmem_address; s_wdata = dmem_wdata; s_be = dmem_byte_enable;
            end
            stalls += int'(MA_stall);
            misses += int'(miss);
            reads  += int'(dmem_read);
            writes += int'(dmem_write);
            if (dmem_read && dmem_write) check("read_write_both_high", 32'd1, 32'd0);
            stall_now = MA_stall;
            @(posedge clk);
            #1;
            if (!stall_now) compare_wb();
        end
        dmem_resp = 1'b0;
        exp_cnt = (exp_cnt + delay > CNT_MAX) ? CNT_MAX : exp_cnt + delay;
        check("stall_cycles", 32'(stall_cycles), 32'(exp_cnt));
        $display("txn instr=%h alu=%h delay=%0d stalls=%0d misses=%0d reads=%0d writes=%0d rdata_wb=%h",
                 instr, alu, delay, stalls, misses, reads, writes, mem_rdata_wb);
    endtask

    int          st, ms, rd, wr;
    logic [31:0] sa, sw;
    logic [3:0]  sb;

    initial begin
        rst = 1'b1;
        ctrl_word_in = '0; instruction_in = '0; PC_in = '0; alu_in = '0; rs2_in = '0;
        mem_byte_enable = '0; addr_offset = '0; br_en_in = 1'b0;
        dmem_rdata = '0; dmem_resp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_alu_wb", alu_wb, 32'h0);
        check("reset_stall_cycles", 32'(stall_cycles), 32'h0);
        check("reset_miss", {31'b0, miss}, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op(I_LW, 32'h1000, 32'h100, 32'h0, 4'b1111, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 3,
               st, ms, rd, wr, sa, sw, sb);
        check("lw_stalls", 32'(st), 32'd3);
        check("lw_misses", 32'(ms), 32'd2);
        check("lw_addr", sa, 32'h100);
        check("lw_be", {28'b0, sb}, 32'hF);
        check("lw_no_write", 32'(wr), 32'd0);

        run_op(I_LB, 32'h1004, 32'h103, 32'h0, 4'b1000, 1'b0, 32'h80FF0000, 32'hFFFFFF80, 1,
               st, ms, rd, wr, sa, sw, sb);
        check("lb_addr", sa, 32'h100);
        run_op(I_LBU, 32'h1008, 32'h103, 32'h0, 4'b1000, 1'b0, 32'h80FF0000, 32'h00000080, 1,
               st, ms, rd, wr, sa, sw, sb);
        run_op(I_LH, 32'h100C, 32'h102, 32'h0, 4'b1100, 1'b0, 32'h80FF0000, 32'hFFFF80FF, 0,
               st, ms, rd, wr, sa, sw, sb);
        check("lh_zero_wait_stalls", 32'(st), 32'd0);
        run_op(I_LHU, 32'h1010, 32'h102, 32'h0, 4'b1100, 1'b0, 32'h80FF0000, 32'h000080FF, 0,
               st, ms, rd, wr, sa, sw, sb);

        run_op(I_SH, 32'h1014, 32'h102, 32'h0000ABCD, 4'b1100, 1'b0, 32'h0, 32'h0, 2,
               st, ms, rd, wr, sa, sw, sb);
        check("sh_wdata", sw, 32'hABCD0000);
        check("sh_be", {28'b0, sb}, 32'hC);
        check("sh_write_cycles", 32'(wr), 32'd3);
        check("sh_no_read", 32'(rd), 32'd0);

        run_op(I_LW, 32'h1018, 32'h200, 32'h0, 4'b1111, 1'b0, 32'h11223344, 32'h11223344, 0,
               st, ms, rd, wr, sa, sw, sb);
        check("b2b_lw_reads", 32'(rd), 32'd1);
        check("b2b_lw_stalls", 32'(st), 32'd0);
        run_op(I_SW, 32'h101C, 32'h204, 32'h55667788, 4'b1111, 1'b0, 32'h0, 32'h0, 0,
               st, ms, rd, wr, sa, sw, sb);
        check("b2b_sw_writes", 32'(wr), 32'd1);
        check("b2b_sw_reads", 32'(rd), 32'd0);
        check("b2b_sw_wdata", sw, 32'h55667788);

        run_op(I_ADD, 32'h1020, 32'h12345678, 32'h9, 4'b0000, 1'b1, 32'h0, 32'h0, 0,
               st, ms, rd, wr, sa, sw, sb);
        check("add_no_request", 32'(rd + wr), 32'd0);
        check("add_no_stall", 32'(st), 32'd0);

        run_op(I_LW, 32'h1024, 32'h300, 32'h0, 4'b1111, 1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5, 20,
               st, ms, rd, wr, sa, sw, sb);
        check("sat_stalls", 32'(st), 32'd20);

        // Reset in the middle of an outstanding load.
        instruction_in = I_LW; alu_in = 32'h400; PC_in = 32'h1028; addr_offset = 2'b00;
        dmem_resp = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("pre_reset_miss", {31'b0, miss}, 32'h1);
        rst = 1'b1;
        #1;
        check("rst_dmem_read", {31'b0, dmem_read}, 32'h0);
        check("rst_MA_stall", {31'b0, MA_stall}, 32'h0);
        check("rst_miss", {31'b0, miss}, 32'h0);
        check("rst_stall_cycles", 32'(stall_cycles), 32'h0);
        check("rst_alu_wb", alu_wb, 32'h0);
        check("rst_instruction_wb", instruction_wb, 32'h0);
        exp_cnt = 0;
        ctrl_word_in = '0; instruction_in = '0; PC_in = '0; alu_in = '0; rs2_in = '0;
        mem_byte_enable = '0; addr_offset = '0; br_en_in = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        dmem_resp = 1'b1;
        dmem_rdata = 32'hCAFEF00D;
        #2;
        check("stray_resp_no_read", {31'b0, dmem_read}, 32'h0);
        @(posedge clk);
        #1;
        dmem_resp = 1'b0;
        check("stray_resp_rdata_wb", mem_rdata_wb, 32'h0);
        check("stray_resp_rmask_wb", {28'b0, rmask_wb}, 32'h0);
        check("stray_resp_stall_cycles", 32'(stall_cycles), 32'h0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
